// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 Hz VGA raster timing generator
// Ports: vga_clk pixel clock; reset async active-high; DrawX/DrawY raster position;
//        hs/vs active-low syncs; blank 1 = visible; frame_start pulse at (0,0);
//        frame_count (16b, only with VGA_TIMING_FRAME_COUNT_EN) frames since reset.
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       vga_clk,
  input  logic       reset,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       hs,
  output logic       vs,
  output logic       blank,
  output logic       frame_start
`ifdef VGA_TIMING_FRAME_COUNT_EN
  ,output logic [15:0] frame_count
`endif
);
  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
  localparam logic [9:0] HS_BEG = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END = 10'(V_VISIBLE + V_FRONT + V_SYNC);
  logic [9:0] hc_q, hc_d, vc_q, vc_d;
  logic       hs_q, hs_d, vs_q, vs_d, blank_q, blank_d, fs_q, fs_d;
  // Syncs and flags decode the next counter values so they align with DrawX/DrawY.
  always_comb begin
    hc_d    = (hc_q == H_LAST) ? '0 : hc_q + 10'd1;
    vc_d    = (hc_q != H_LAST) ? vc_q : (vc_q == V_LAST) ? '0 : vc_q + 10'd1;
    hs_d    = !(hc_d >= HS_BEG && hc_d < HS_END);
    vs_d    = !(vc_d >= VS_BEG && vc_d < VS_END);
    blank_d = (hc_d < H_VIS) && (vc_d < V_VIS);
    fs_d    = (hc_d == '0) && (vc_d == '0);
  end
  always_ff @(posedge vga_clk or posedge reset)
    if (reset) begin
      hc_q    <= H_LAST;
      vc_q    <= V_LAST;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      blank_q <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      hc_q    <= hc_d;
      vc_q    <= vc_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      blank_q <= blank_d;
      fs_q    <= fs_d;
    end
  assign DrawX       = hc_q;
  assign DrawY       = vc_q;
  assign hs          = hs_q;
  assign vs          = vs_q;
  assign blank       = blank_q;
  assign frame_start = fs_q;
`ifdef VGA_TIMING_FRAME_COUNT_EN
  logic [15:0] fc_q, fc_d;
  always_comb fc_d = fs_d ? fc_q + 16'd1 : fc_q;
  always_ff @(posedge vga_clk or posedge reset)
    if (reset) fc_q <= '0;
    else fc_q <= fc_d;
  assign frame_count = fc_q;
`endif
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: randomized self-checking bench for vga_timing_gen
module tb_vga_timing_gen;
  localparam int SHV = 64, SHF = 4, SHS = 8, SHB = 6;
  localparam int SVV = 20, SVF = 3, SVS = 2, SVB = 5;
  localparam int SHT = SHV + SHF + SHS + SHB;
  localparam int SVT = SVV + SVF + SVS + SVB;
  localparam int SFR = SHT * SVT;
  logic vga_clk = 1'b0;
  logic reset = 1'b1;
  logic [9:0] dx_a, dy_a, dx_b, dy_b;
  logic hs_a, vs_a, blank_a, fs_a, hs_b, vs_b, blank_b, fs_b;
  logic [23:0] obs_a, obs_b;
  int tests = 0, fails = 0;
  int n = -1;
`ifdef VGA_TIMING_FRAME_COUNT_EN
  logic [15:0] fc_a, fc_b;
`endif
  vga_timing_gen dut_a (
    .vga_clk(vga_clk), .reset(reset), .DrawX(dx_a), .DrawY(dy_a),
    .hs(hs_a), .vs(vs_a), .blank(blank_a), .frame_start(fs_a)
`ifdef VGA_TIMING_FRAME_COUNT_EN
    , .frame_count(fc_a)
`endif
  );
  vga_timing_gen #(
    .H_VISIBLE(SHV), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
    .V_VISIBLE(SVV), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB)
  ) dut_b (
    .vga_clk(vga_clk), .reset(reset), .DrawX(dx_b), .DrawY(dy_b),
    .hs(hs_b), .vs(vs_b), .blank(blank_b), .frame_start(fs_b)
`ifdef VGA_TIMING_FRAME_COUNT_EN
    , .frame_count(fc_b)
`endif
  );
  assign obs_a = {dx_a, dy_a, hs_a, vs_a, blank_a, fs_a};
  assign obs_b = {dx_b, dy_b, hs_b, vs_b, blank_b, fs_b};
  always #5 vga_clk = ~vga_clk;
  // k = pixel clocks since reset release (negative while in reset).
  function automatic logic [23:0] model(input int k, input int hv, input int hf, input int hw,
                                        input int hb, input int vv, input int vf, input int vw,
                                        input int vb);
    int ht = hv + hf + hw + hb;
    int vt = vv + vf + vw + vb;
    int x = (k < 0) ? ht - 1 : k % ht;
    int y = (k < 0) ? vt - 1 : (k / ht) % vt;
    return {10'(x), 10'(y), !(x >= hv + hf && x < hv + hf + hw),
            !(y >= vv + vf && y < vv + vf + vw), (x < hv && y < vv), (k >= 0 && x == 0 && y == 0)};
  endfunction
  function automatic logic [23:0] exp_a();
    return model(n, 640, 16, 96, 48, 480, 10, 2, 33);
  endfunction
  function automatic logic [23:0] exp_b();
    return model(n, SHV, SHF, SHS, SHB, SVV, SVF, SVS, SVB);
  endfunction
  task automatic tick();
    @(posedge vga_clk);
    if (!reset) n++;
    #1;
  endtask
  task automatic test_reset();
    reset = 1'b1;
    n = -1;
    repeat (3) tick();
    tests += 2;
    if (obs_a !== exp_a()) begin fails++; $display("FAIL reset_a: got %h want %h", obs_a, exp_a()); end
    if (obs_b !== exp_b()) begin fails++; $display("FAIL reset_b: got %h want %h", obs_b, exp_b()); end
    #2 reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      tests += 2;
      if (obs_a !== exp_a()) begin fails++; $display("FAIL release_a: cyc %0d got %h want %h", i, obs_a, exp_a()); end
      if (obs_b !== exp_b()) begin fails++; $display("FAIL release_b: cyc %0d got %h want %h", i, obs_b, exp_b()); end
    end
  endtask
  task automatic test_line();
    int hs_low = 0, vis = 0;
    for (int i = 0; i < 1700; i++) begin
      tick();
      tests += 2;
      if (obs_a !== exp_a()) begin fails++; $display("FAIL line_a: n %0d got %h want %h", n, obs_a, exp_a()); end
      if (obs_b !== exp_b()) begin fails++; $display("FAIL line_b: n %0d got %h want %h", n, obs_b, exp_b()); end
      if (n >= 800 && n < 1600) begin
        hs_low += !hs_a;
        vis += blank_a;
      end
    end
    tests += 2;
    if (hs_low != 96) begin fails++; $display("FAIL hs_width: got %0d want 96", hs_low); end
    if (vis != 640) begin fails++; $display("FAIL line_visible: got %0d want 640", vis); end
  endtask
  task automatic test_frame();
    int last = -1, vis = 0, vlow = 0, pulses = 0;
    for (int i = 0; i < 3 * SFR; i++) begin
      tick();
      tests += 2;
      if (obs_a !== exp_a()) begin fails++; $display("FAIL frame_a: n %0d got %h want %h", n, obs_a, exp_a()); end
      if (obs_b !== exp_b()) begin fails++; $display("FAIL frame_b: n %0d got %h want %h", n, obs_b, exp_b()); end
      if (fs_b) begin
        if (last >= 0) begin
          tests += 3;
          if (i - last != SFR) begin fails++; $display("FAIL frame_period: got %0d want %0d", i - last, SFR); end
          if (vis != SHV * SVV) begin fails++; $display("FAIL frame_visible: got %0d want %0d", vis, SHV * SVV); end
          if (vlow != SVS * SHT) begin fails++; $display("FAIL vs_width: got %0d want %0d", vlow, SVS * SHT); end
        end
        last = i;
        pulses++;
        vis = 0;
        vlow = 0;
      end
      vis += blank_b;
      vlow += !vs_b;
    end
    tests++;
    if (pulses < 2) begin fails++; $display("FAIL frame_pulses: got %0d want >=2", pulses); end
  endtask
  task automatic test_sync_reset();
    int target = (SVV + SVF + 1) * SHT + SHV + SHF + 2;
    for (int i = 0; i < 2 * SFR && n % SFR != target; i++) tick();
    tests += 2;
    if ({hs_b, vs_b} !== 2'b00) begin fails++; $display("FAIL sync_before_reset: got %b want 00", {hs_b, vs_b}); end
    if (obs_b !== exp_b()) begin fails++; $display("FAIL sync_pos: got %h want %h", obs_b, exp_b()); end
    #2 reset = 1'b1;
    n = -1;
    #1;
    tests += 2;
    if ({hs_b, vs_b, blank_b} !== 3'b110) begin fails++; $display("FAIL async_sync_b: got %b want 110", {hs_b, vs_b, blank_b}); end
    if (obs_a !== exp_a()) begin fails++; $display("FAIL async_a: got %h want %h", obs_a, exp_a()); end
    tick();
    #1 reset = 1'b0;
    tick();
    tests += 2;
    if (obs_a !== exp_a()) begin fails++; $display("FAIL restart_a: got %h want %h", obs_a, exp_a()); end
    if (obs_b !== exp_b()) begin fails++; $display("FAIL restart_b: got %h want %h", obs_b, exp_b()); end
  endtask
  task automatic test_random_reset();
    for (int r = 0; r < 6; r++) begin
      int len = int'($urandom_range(1, 2 * SFR));
      for (int i = 0; i < len; i++) begin
        tick();
        tests++;
        if (obs_b !== exp_b()) begin fails++; $display("FAIL rnd_run_b: n %0d got %h want %h", n, obs_b, exp_b()); end
      end
      #($urandom_range(1, 3)) reset = 1'b1;
      n = -1;
      #1;
      tests += 2;
      if (obs_a !== exp_a()) begin fails++; $display("FAIL rnd_async_a: got %h want %h", obs_a, exp_a()); end
      if (obs_b !== exp_b()) begin fails++; $display("FAIL rnd_async_b: got %h want %h", obs_b, exp_b()); end
      repeat ($urandom_range(1, 3)) tick();
      #1 reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
        tick();
        tests += 2;
        if (obs_a !== exp_a()) begin fails++; $display("FAIL rnd_restart_a: got %h want %h", obs_a, exp_a()); end
        if (obs_b !== exp_b()) begin fails++; $display("FAIL rnd_restart_b: got %h want %h", obs_b, exp_b()); end
      end
    end
  endtask
`ifdef VGA_TIMING_FRAME_COUNT_EN
  task automatic test_frame_count();
    reset = 1'b1;
    n = -1;
    #1;
    tests++;
    if (fc_b !== 16'd0) begin fails++; $display("FAIL fc_reset: got %0d want 0", fc_b); end
    tick();
    #1 reset = 1'b0;
    for (int i = 0; i < 3 * SFR - 1; i++) begin
      tick();
      tests += 2;
      if (fc_b !== 16'(n / SFR + 1)) begin fails++; $display("FAIL fc_b: n %0d got %0d want %0d", n, fc_b, n / SFR + 1); end
      if (fc_a !== 16'd1) begin fails++; $display("FAIL fc_a: got %0d want 1", fc_a); end
    end
    tests++;
    if (fc_b !== 16'd3) begin fails++; $display("FAIL fc_three: got %0d want 3", fc_b); end
  endtask
`endif
  initial begin
    test_reset();
    test_line();
    test_frame();
    test_sync_reset();
    test_random_reset();
`ifdef VGA_TIMING_FRAME_COUNT_EN
    test_frame_count();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
